// File: rtl/mrh_pkg.sv
// Shared types and constants for the mrh dispatch stage.
package mrh_pkg;

  localparam int DISP_SIZE      = 4;
  localparam int ALU_NUM        = 2;
  localparam int ALU_ENTRY_SIZE = 32;
  localparam int SLOTS_PER_ALU  = 2;
  localparam int RANK_W         = $clog2(DISP_SIZE + 1);
  localparam int NEED_W         = $clog2(SLOTS_PER_ALU + 1);

  typedef struct packed {
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } disp_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } disp_state_t;

  function automatic logic [RANK_W-1:0] popcount(input logic [DISP_SIZE-1:0] v);
    logic [RANK_W-1:0] c;
    c = '0;
    for (int i = 0; i < DISP_SIZE; i++) c = c + RANK_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/disp_if.sv
// Dispatch bus from the dispatch controller (master) to the ALU schedulers.
interface disp_if;
  import mrh_pkg::*;

  disp_t [DISP_SIZE-1:0] inst;

  modport master (output inst);
  modport slave  (input  inst);

endinterface

// File: rtl/mrh_disp_credit.sv
// Free-entry credit counter for one ALU scheduler; reports whether a group's
// share of slots fits into the entries known to be free.
module mrh_disp_credit
  import mrh_pkg::*;
#(
  parameter int  ENTRY_SIZE = ALU_ENTRY_SIZE,
  localparam int CREDIT_W   = $clog2(ENTRY_SIZE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NEED_W-1:0]   need,
  input  logic                accept,
  input  logic                issue,
  input  logic                reload,
  output logic [CREDIT_W-1:0] credit,
  output logic                fit
);

  localparam logic [CREDIT_W:0] FULL = (CREDIT_W + 1)'(ENTRY_SIZE);

  logic [CREDIT_W:0] sum;

  // Only the registered count decides fit; a return arriving now helps next cycle.
  assign fit = (CREDIT_W'(need) <= credit);

  always_comb begin
    sum = {1'b0, credit} + (CREDIT_W + 1)'(issue);
    if (accept) sum = sum - (CREDIT_W + 1)'(need);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= CREDIT_W'(ENTRY_SIZE);
    end else if (reload) begin
      credit <= CREDIT_W'(ENTRY_SIZE);
    end else if (sum > FULL) begin
      credit <= CREDIT_W'(ENTRY_SIZE);
    end else begin
      credit <= sum[CREDIT_W-1:0];
    end
  end

  // A return while already holding every entry means the scheduler lost count.
  credit_no_overflow: assert property (@(posedge clk) disable iff (rst) !reload |-> (sum <= FULL));

endmodule

// File: rtl/mrh_disp_ctrl.sv
// Dispatch controller: accepts decoded groups, checks ALU scheduler credits and
// registers the group onto disp. Optional stall counter with MRH_DISP_PERF_EN.
module mrh_disp_ctrl
  import mrh_pkg::*;
#(
  parameter int  ENTRY_SIZE = ALU_ENTRY_SIZE,
  localparam int CREDIT_W   = $clog2(ENTRY_SIZE + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_dec_valid,
  input  logic [DISP_SIZE-1:0]              i_dec_inst_valid,
  input  disp_t [DISP_SIZE-1:0]             i_dec_inst,
  output logic                              o_dec_ready,
  output logic [DISP_SIZE-1:0]              o_disp_valid,
  disp_if.master                            disp,
  input  logic [ALU_NUM-1:0]                i_alu_issue,
  input  logic                              i_flush,
`ifdef MRH_DISP_PERF_EN
  output logic [31:0]                       o_perf_stall_cnt,
`endif
  output disp_state_t                       o_dbg_state,
  output logic [ALU_NUM-1:0][CREDIT_W-1:0]  o_dbg_credit
);

  // Handshake: a group moves when i_dec_valid && o_dec_ready in the same cycle;
  // o_dec_ready is combinational and does not depend on i_dec_valid.

  disp_state_t                          state;
  logic [DISP_SIZE-1:0][RANK_W-1:0]     rank;
  logic [DISP_SIZE-1:0]                 slot_keep;
  logic [ALU_NUM-1:0][NEED_W-1:0]       need;
  logic [ALU_NUM-1:0]                   fit_k;
  logic                                 fit;
  logic                                 flushing;
  logic                                 accept;

  // Slot i lands on ALU rank(i)/2, rank being the number of valid slots below it.
  always_comb begin
    rank      = '0;
    slot_keep = '0;
    need      = '0;
    for (int i = 0; i < DISP_SIZE; i++) begin
      rank[i] = popcount(i_dec_inst_valid & ((DISP_SIZE'(1) << i) - DISP_SIZE'(1)));
      slot_keep[i] = i_dec_inst_valid[i] && (int'(rank[i]) < SLOTS_PER_ALU * ALU_NUM);
      for (int k = 0; k < ALU_NUM; k++) begin
        if (i_dec_inst_valid[i] && ((int'(rank[i]) / SLOTS_PER_ALU) == k)) begin
          need[k] = need[k] + NEED_W'(1);
        end
      end
    end
  end

  assign fit         = &fit_k;
  assign flushing    = i_flush || (state == FLUSH);
  assign o_dec_ready = !i_reset && !flushing && fit;
  assign accept      = i_dec_valid && o_dec_ready;
  assign o_dbg_state = state;

  for (genvar k = 0; k < ALU_NUM; k++) begin : g_credit
    mrh_disp_credit #(
      .ENTRY_SIZE (ENTRY_SIZE)
    ) u_credit (
      .clk    (i_clk),
      .rst    (i_reset),
      .need   (need[k]),
      .accept (accept),
      .issue  (i_alu_issue[k]),
      .reload (flushing),
      .credit (o_dbg_credit[k]),
      .fit    (fit_k[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= RUN;
      o_disp_valid <= '0;
      disp.inst    <= '0;
    end else begin
      o_disp_valid <= accept ? slot_keep : '0;
      if (accept) disp.inst <= i_dec_inst;
      if (i_flush) begin
        state <= FLUSH;
      end else begin
        case (state)
          RUN:     if (i_dec_valid && !fit) state <= STALL;
          STALL:   if (accept) state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef MRH_DISP_PERF_EN
  // Flush cycles hold ready low by design and are not stalls.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_perf_stall_cnt <= '0;
    end else if (i_dec_valid && !o_dec_ready && !flushing && (o_perf_stall_cnt != '1)) begin
      o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
    end
  end
`endif

  group_width_legal: assert property (@(posedge i_clk) disable iff (i_reset)
    i_dec_valid |-> (popcount(i_dec_inst_valid) <= RANK_W'(SLOTS_PER_ALU * ALU_NUM)));

endmodule

// File: tb/tb_mrh_disp_ctrl.sv
// Bench for mrh_disp_ctrl: constant vector table, directed stall/flush/reset
// sequences, and randomized traffic against a group-level credit model.
module tb_mrh_disp_ctrl;
  import mrh_pkg::*;

  localparam int CW = $clog2(ALU_ENTRY_SIZE + 1);
  localparam int IW = DISP_SIZE * $bits(disp_t);
  localparam int W  = DISP_SIZE + IW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                         dec_valid;
  logic [DISP_SIZE-1:0]         dec_mask;
  disp_t [DISP_SIZE-1:0]        dec_inst;
  logic                         dec_ready;
  logic [DISP_SIZE-1:0]         disp_valid;
  logic [ALU_NUM-1:0]           alu_issue;
  logic                         flush;
  disp_state_t                  dbg_state;
  logic [ALU_NUM-1:0][CW-1:0]   dbg_credit;
`ifdef MRH_DISP_PERF_EN
  logic [31:0]                  perf_cnt;
`endif

  disp_if disp();

  mrh_disp_ctrl dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_dec_valid      (dec_valid),
    .i_dec_inst_valid (dec_mask),
    .i_dec_inst       (dec_inst),
    .o_dec_ready      (dec_ready),
    .o_disp_valid     (disp_valid),
    .disp             (disp),
    .i_alu_issue      (alu_issue),
    .i_flush          (flush),
`ifdef MRH_DISP_PERF_EN
    .o_perf_stall_cnt (perf_cnt),
`endif
    .o_dbg_state      (dbg_state),
    .o_dbg_credit     (dbg_credit)
  );

  // ---------------- reference model + scoreboard ----------------
  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_credit[ALU_NUM];
  bit            m_flush_st;
  bit            m_stall;
  int            m_perf;
  logic [W-1:0]  exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < ALU_NUM; k++) m_credit[k] = ALU_ENTRY_SIZE;
    m_flush_st = 1'b0;
    m_stall    = 1'b0;
    m_perf     = 0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive, check combinational/state outputs, clock, check dispatch.
  task automatic cycle(input logic v, input logic [DISP_SIZE-1:0] mask,
                       input logic [ALU_NUM-1:0] iss, input logic fl,
                       output logic rdy_seen);
    logic [63:0]   r;
    int            pop, need0, need1;
    bit            fit, exp_rdy, acc;
    disp_state_t   exp_st;
    logic [W-1:0]  exp;
    dec_valid = v;
    dec_mask  = mask;
    alu_issue = iss;
    flush     = fl;
    for (int i = 0; i < DISP_SIZE; i++) begin
      r = {$urandom(), $urandom()};
      dec_inst[i] = r[$bits(disp_t)-1:0];
    end
    #1;
    pop     = $countones(mask);
    need0   = (pop > 2) ? 2 : pop;
    need1   = (pop > 2) ? pop - 2 : 0;
    fit     = (need0 <= m_credit[0]) && (need1 <= m_credit[1]);
    exp_rdy = !fl && !m_flush_st && fit;
    acc     = v && exp_rdy;
    exp_st  = m_flush_st ? FLUSH : (m_stall ? STALL : RUN);
    rdy_seen = dec_ready;
    check("ready", 64'(dec_ready), 64'(exp_rdy));
    check("credit0", 64'(dbg_credit[0]), 64'(m_credit[0]));
    check("credit1", 64'(dbg_credit[1]), 64'(m_credit[1]));
    check("state", 64'(dbg_state), 64'(exp_st));
`ifdef MRH_DISP_PERF_EN
    check("perf", 64'(perf_cnt), 64'(m_perf));
`endif
    exp_q.push_back({acc ? mask : 4'b0000, dec_inst});
    if (v && !exp_rdy && !fl && !m_flush_st) m_perf++;
    if (fl || m_flush_st) begin
      for (int k = 0; k < ALU_NUM; k++) m_credit[k] = ALU_ENTRY_SIZE;
    end else begin
      m_credit[0] = m_credit[0] + int'(iss[0]) - (acc ? need0 : 0);
      m_credit[1] = m_credit[1] + int'(iss[1]) - (acc ? need1 : 0);
    end
    if (fl || m_flush_st || acc) m_stall = 1'b0;
    else if (v && !fit)           m_stall = 1'b1;
    m_flush_st = fl;
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("disp_valid", 64'(disp_valid), 64'(exp[W-1 -: DISP_SIZE]));
    if (exp[W-1 -: DISP_SIZE] != '0) begin
      n_tests++;
      if (disp.inst !== exp[IW-1:0]) begin
        n_fail++;
        $display("FAIL disp_inst: got %0h expected %0h at %0t", disp.inst, exp[IW-1:0], $time);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dec_valid = 1'b0; dec_mask = '0; alu_issue = '0; flush = 1'b0; dec_inst = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(dec_ready), 64'(0));
    check("rst_valid", 64'(disp_valid), 64'(0));
    check("rst_credit0", 64'(dbg_credit[0]), 64'(ALU_ENTRY_SIZE));
    check("rst_credit1", 64'(dbg_credit[1]), 64'(ALU_ENTRY_SIZE));
    check("rst_state", 64'(dbg_state), 64'(RUN));
    check("rst_inst", 64'(disp.inst[0]), 64'(0));
`ifdef MRH_DISP_PERF_EN
    check("rst_perf", 64'(perf_cnt), 64'(0));
`endif
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic                 v;
    logic [DISP_SIZE-1:0] mask;
    logic [ALU_NUM-1:0]   iss;
    logic                 fl;
    logic                 rdy;
    logic [DISP_SIZE-1:0] dv;
    int                   c0;
    int                   c1;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic rs;
    int   perf_base;

    tbl[0] = '{1'b0, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000, 32, 32};
    tbl[1] = '{1'b1, 4'b1111, 2'b00, 1'b0, 1'b1, 4'b1111, 30, 30};
    tbl[2] = '{1'b1, 4'b1010, 2'b00, 1'b0, 1'b1, 4'b1010, 28, 30};
    tbl[3] = '{1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000, 28, 30};
    tbl[4] = '{1'b1, 4'b0001, 2'b10, 1'b0, 1'b1, 4'b0001, 27, 31};
    tbl[5] = '{1'b1, 4'b1111, 2'b00, 1'b1, 1'b0, 4'b0000, 32, 32};
    tbl[6] = '{1'b1, 4'b1111, 2'b00, 1'b0, 1'b0, 4'b0000, 32, 32};
    tbl[7] = '{1'b1, 4'b0110, 2'b00, 1'b0, 1'b1, 4'b0110, 30, 32};
    tbl[8] = '{1'b0, 4'b0000, 2'b01, 1'b0, 1'b1, 4'b0000, 31, 32};

    do_reset();

    for (int t = 0; t < 9; t++) begin
      cycle(tbl[t].v, tbl[t].mask, tbl[t].iss, tbl[t].fl, rs);
      check($sformatf("tbl%0d_ready", t), 64'(rs), 64'(tbl[t].rdy));
      check($sformatf("tbl%0d_valid", t), 64'(disp_valid), 64'(tbl[t].dv));
      check($sformatf("tbl%0d_c0", t), 64'(dbg_credit[0]), 64'(tbl[t].c0));
      check($sformatf("tbl%0d_c1", t), 64'(dbg_credit[1]), 64'(tbl[t].c1));
    end

    // Drain ALU0 to a single free entry without returns.
    while (m_credit[0] > 1) cycle(1'b1, (m_credit[0] >= 3) ? 4'b0011 : 4'b0001, 2'b00, 1'b0, rs);
    check("drained_c0", 64'(dbg_credit[0]), 64'(1));
    perf_base = m_perf;

    for (int s = 0; s < 4; s++) begin
      cycle(1'b1, 4'b0011, 2'b00, 1'b0, rs);
      check("stall_ready", 64'(rs), 64'(0));
      check("stall_state", 64'(dbg_state), 64'(STALL));
    end
    cycle(1'b1, 4'b0011, 2'b01, 1'b0, rs);
    check("return_same_cycle_ready", 64'(rs), 64'(0));
    cycle(1'b1, 4'b0011, 2'b00, 1'b0, rs);
    check("unstall_ready", 64'(rs), 64'(1));
    check("unstall_valid", 64'(disp_valid), 64'(4'b0011));
    check("unstall_c0", 64'(dbg_credit[0]), 64'(0));
    check("unstall_state", 64'(dbg_state), 64'(RUN));
`ifdef MRH_DISP_PERF_EN
    check("perf_five_stalls", 64'(perf_cnt), 64'(perf_base + 5));
`endif

    // Zero credit with a same-cycle return: stall now, fit next cycle.
    cycle(1'b1, 4'b0001, 2'b01, 1'b0, rs);
    check("zero_credit_ready", 64'(rs), 64'(0));
    cycle(1'b1, 4'b0001, 2'b00, 1'b0, rs);
    check("zero_credit_next_ready", 64'(rs), 64'(1));
    check("zero_credit_valid", 64'(disp_valid), 64'(4'b0001));

    // Flush coinciding with a valid group.
    cycle(1'b1, 4'b1111, 2'b00, 1'b1, rs);
    check("flush_ready", 64'(rs), 64'(0));
    check("flush_valid", 64'(disp_valid), 64'(0));
    check("flush_c0", 64'(dbg_credit[0]), 64'(ALU_ENTRY_SIZE));
    cycle(1'b1, 4'b1111, 2'b00, 1'b0, rs);
    check("flush_state_ready", 64'(rs), 64'(0));
    cycle(1'b1, 4'b1111, 2'b00, 1'b0, rs);
    check("post_flush_ready", 64'(rs), 64'(1));
    check("post_flush_valid", 64'(disp_valid), 64'(4'b1111));
`ifdef MRH_DISP_PERF_EN
    check("perf_flush_excluded", 64'(perf_cnt), 64'(perf_base + 6));
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [ALU_NUM-1:0] iss;
      logic fl;
      fl = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < ALU_NUM; k++)
        iss[k] = (m_credit[k] < ALU_ENTRY_SIZE) && !m_flush_st && !fl && ($urandom_range(0, 2) != 0);
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), iss, fl, rs);
    end

    // Asynchronous reset in the middle of a cycle with a group on the bus.
    cycle(1'b0, 4'b0000, 2'b00, 1'b1, rs);
    cycle(1'b0, 4'b0000, 2'b00, 1'b0, rs);
    cycle(1'b1, 4'b1111, 2'b00, 1'b0, rs);
    check("pre_reset_valid", 64'(disp_valid), 64'(4'b1111));
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(disp_valid), 64'(0));
    check("async_rst_c0", 64'(dbg_credit[0]), 64'(ALU_ENTRY_SIZE));
    check("async_rst_c1", 64'(dbg_credit[1]), 64'(ALU_ENTRY_SIZE));
    check("async_rst_ready", 64'(dec_ready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 4'b0000, 2'b00, 1'b0, rs);
    check("after_rst_ready", 64'(rs), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
